annunciator_arbiter: RTL

- Shares the clock's single LED indicator between three requesters: hourly chime, alarm, and countdown-timer expiry.
- Detects chime and alarm triggers from the timekeeping counters and latches each request as pending.
- Grants the LED to the highest-priority pending request, sequences its blink pattern, and handles alarm acknowledge and snooze.
- Sits between the timekeeper/timer blocks and the LED pin. It replaces direct LED drive by the chime logic.

---
 rtl/annunciator_arbiter.sv | 226 ++++++++++++++++++++++
 1 files changed

// File: rtl/annunciator_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : annunciator_arbiter
// Brief    : Arbitrates the single LED indicator between hourly chime, timer
//            expiry and alarm; sequences blink sessions, ack and snooze.
// Revision : 1.0  initial release
// ============================================================================
module annunciator_arbiter #(
    parameter int ALARM_TOGGLES = 60,
    parameter int TIMER_TOGGLES = 10,
    parameter int SNOOZE_SECS   = 300
) (
    input  logic       clk_1Hz,
    input  logic       reset,
    input  logic [5:0] hour,
    input  logic [5:0] minute,
    input  logic [5:0] second,
    input  logic       alarm_en,
    input  logic [5:0] alarm_hour,
    input  logic [5:0] alarm_minute,
    input  logic       timer_done,
    input  logic       ack,
    input  logic       snooze,
    output logic       LED,
    output logic [1:0] active_src,
    output logic       snooze_active
);

    localparam int c_REM_MAX0 = (ALARM_TOGGLES > TIMER_TOGGLES) ? ALARM_TOGGLES : TIMER_TOGGLES;
    localparam int c_REM_MAX  = (c_REM_MAX0 > 24) ? c_REM_MAX0 : 24;
    localparam int c_REM_W    = $clog2(c_REM_MAX + 1);
    localparam int c_SNZ_W    = $clog2(SNOOZE_SECS + 1);

    localparam logic [c_REM_W-1:0] c_ALARM_LOAD = c_REM_W'(ALARM_TOGGLES);
    localparam logic [c_REM_W-1:0] c_TIMER_LOAD = c_REM_W'(TIMER_TOGGLES);
    localparam logic [c_REM_W-1:0] c_REM_ONE    = c_REM_W'(1);
    localparam logic [c_SNZ_W-1:0] c_SNZ_LOAD   = c_SNZ_W'(SNOOZE_SECS);
    localparam logic [c_SNZ_W-1:0] c_SNZ_ONE    = c_SNZ_W'(1);

    // State codes double as the active_src encoding.
    localparam logic [1:0] S_IDLE  = 2'b00;
    localparam logic [1:0] S_CHIME = 2'b01;
    localparam logic [1:0] S_TIMER = 2'b10;
    localparam logic [1:0] S_ALARM = 2'b11;

    logic [1:0]         r_state;
    logic [1:0]         w_state_nx;
    logic               r_led;
    logic               w_led_nx;
    logic [c_REM_W-1:0] r_rem;
    logic [c_REM_W-1:0] w_rem_nx;

    logic               r_chime_pend;
    logic               r_timer_pend;
    logic               r_alarm_pend;
    logic               w_chime_pend_nx;
    logic               w_timer_pend_nx;
    logic               w_alarm_pend_nx;
    logic [4:0]         r_chime_cnt;
    logic [4:0]         w_chime_cnt_nx;
    logic [4:0]         w_h12;
    logic [4:0]         w_chime_load;

    logic               r_snooze_active;
    logic               w_snooze_active_nx;
    logic [c_SNZ_W-1:0] r_snooze_cnt;
    logic [c_SNZ_W-1:0] w_snooze_cnt_nx;

    logic               w_chime_trig;
    logic               w_alarm_match;
    logic               w_snooze_expire;
    logic               w_alarm_trig;
    logic               w_alarm_ready;
    logic               w_session_last;
    logic               w_grant_alarm;
    logic               w_grant_timer;
    logic               w_grant_chime;
    logic               w_snooze_arm;

    // ------------------------------------------------------------------
    // Trigger detection
    // ------------------------------------------------------------------
    assign w_chime_trig    = (minute == 6'd0) && (second == 6'd0) && (hour <= 6'd23);
    assign w_alarm_match   = alarm_en && (hour == alarm_hour) && (minute == alarm_minute)
                             && (second == 6'd0);
    // The edge on which the count steps from 1 to 0 is the re-trigger edge.
    assign w_snooze_expire = r_snooze_active && (r_snooze_cnt <= c_SNZ_ONE);
    assign w_alarm_trig    = w_alarm_match || w_snooze_expire;
    // ack withdraws a pending alarm on the same edge, so it must not be granted.
    assign w_alarm_ready   = r_alarm_pend && !ack;
    assign w_session_last  = (r_rem <= c_REM_ONE);

    always_comb begin
        w_h12 = hour[4:0];
        if (hour == 6'd0) begin
            w_h12 = 5'd12;
        end else if (hour > 6'd12) begin
            w_h12 = hour[4:0] - 5'd12;
        end
    end

    assign w_chime_load = w_h12 + w_h12;

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        w_state_nx    = r_state;
        w_led_nx      = r_led;
        w_rem_nx      = r_rem;
        w_grant_alarm = 1'b0;
        w_grant_timer = 1'b0;
        w_grant_chime = 1'b0;
        w_snooze_arm  = 1'b0;

        case (r_state)
            S_IDLE: begin
                w_led_nx = 1'b0;
                if (w_alarm_ready) begin
                    w_state_nx    = S_ALARM;
                    w_rem_nx      = c_ALARM_LOAD;
                    w_grant_alarm = 1'b1;
                end else if (r_timer_pend) begin
                    w_state_nx    = S_TIMER;
                    w_rem_nx      = c_TIMER_LOAD;
                    w_grant_timer = 1'b1;
                end else if (r_chime_pend) begin
                    w_state_nx    = S_CHIME;
                    w_rem_nx      = c_REM_W'(r_chime_cnt);
                    w_grant_chime = 1'b1;
                end
            end

            S_ALARM: begin
                if (ack || snooze || w_session_last) begin
                    w_state_nx   = S_IDLE;
                    w_led_nx     = 1'b0;
                    w_rem_nx     = '0;
                    w_snooze_arm = snooze && !ack;
                end else begin
                    w_led_nx = ~r_led;
                    w_rem_nx = r_rem - c_REM_ONE;
                end
            end

            S_CHIME, S_TIMER: begin
                // A pending alarm aborts the session; the aborted request is dropped.
                if (w_alarm_ready || w_session_last) begin
                    w_state_nx = S_IDLE;
                    w_led_nx   = 1'b0;
                    w_rem_nx   = '0;
                end else begin
                    w_led_nx = ~r_led;
                    w_rem_nx = r_rem - c_REM_ONE;
                end
            end

            default: begin
                w_state_nx = S_IDLE;
                w_led_nx   = 1'b0;
                w_rem_nx   = '0;
            end
        endcase

        // New requests win over the clear caused by a grant on the same edge.
        w_chime_pend_nx = w_chime_trig || (r_chime_pend && !w_grant_chime);
        w_chime_cnt_nx  = w_chime_trig ? w_chime_load : r_chime_cnt;
        w_timer_pend_nx = timer_done || (r_timer_pend && !w_grant_timer);
        w_alarm_pend_nx = !ack && ((w_alarm_trig && (r_state != S_ALARM))
                                   || (r_alarm_pend && !w_grant_alarm));

        w_snooze_active_nx = r_snooze_active;
        w_snooze_cnt_nx    = r_snooze_cnt;
        if (ack) begin
            w_snooze_active_nx = 1'b0;
            w_snooze_cnt_nx    = '0;
        end else if (w_snooze_arm) begin
            w_snooze_active_nx = 1'b1;
            w_snooze_cnt_nx    = c_SNZ_LOAD;
        end else if (w_snooze_expire) begin
            w_snooze_active_nx = 1'b0;
            w_snooze_cnt_nx    = '0;
        end else if (r_snooze_active) begin
            w_snooze_cnt_nx = r_snooze_cnt - c_SNZ_ONE;
        end
    end

    // ------------------------------------------------------------------
    // State and datapath registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk_1Hz) begin
        if (reset) begin
            r_state         <= S_IDLE;
            r_led           <= 1'b0;
            r_rem           <= '0;
            r_chime_pend    <= 1'b0;
            r_timer_pend    <= 1'b0;
            r_alarm_pend    <= 1'b0;
            r_chime_cnt     <= '0;
            r_snooze_active <= 1'b0;
            r_snooze_cnt    <= '0;
        end else begin
            r_state         <= w_state_nx;
            r_led           <= w_led_nx;
            r_rem           <= w_rem_nx;
            r_chime_pend    <= w_chime_pend_nx;
            r_timer_pend    <= w_timer_pend_nx;
            r_alarm_pend    <= w_alarm_pend_nx;
            r_chime_cnt     <= w_chime_cnt_nx;
            r_snooze_active <= w_snooze_active_nx;
            r_snooze_cnt    <= w_snooze_cnt_nx;
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    always_comb begin
        LED           = r_led;
        active_src    = r_state;
        snooze_active = r_snooze_active;
    end

endmodule

`default_nettype wire
